// File: rtl/core_msg_rx_pkg.sv
// Shared definitions for the core-side message receiver: header field layout,
// fence encodings, task frame size and receiver state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package core_msg_rx_pkg;

    // Instruction words per instruction frame
    localparam int FRAME_WORDS = 16;

    // Header word field masks
    localparam logic [15:0] HDR_IFNUM_MASK = 16'h003F;   // [5:0] instruction frame count
    localparam logic [15:0] HDR_FENCE_MASK = 16'h00C0;   // [7:6] fence

    // Fence encodings carried in the header
    localparam logic [1:0] SCHED_FENCE_NONE = 2'b00;
    localparam logic [1:0] SCHED_FENCE_ACQ  = 2'b01;
    localparam logic [1:0] SCHED_FENCE_REL  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_MASK   = 3'd2,
        ST_R0VEC  = 3'd3,
        ST_R0DATA = 3'd4,
        ST_INSTR  = 3'd5,
        ST_EXEC   = 3'd6
    } rx_state_t;

    function automatic logic [5:0] hdr_if_num(input logic [15:0] w);
        logic [15:0] f;
        f = w & HDR_IFNUM_MASK;
        return f[5:0];
    endfunction

    function automatic logic [1:0] hdr_fence(input logic [15:0] w);
        logic [15:0] f;
        f = w & HDR_FENCE_MASK;
        return f[7:6];
    endfunction

endpackage

// File: rtl/core_msg_rx_ibuf.sv
// Local instruction buffer: simple dual-port RAM, one write port, one registered read port.
// Latency: write lands at the clock edge; read data valid one cycle after raddr.
// Backpressure: none, both ports accept every cycle.
// Ports: clk, reset (async active-low, clears only the read register), we/waddr/wdata
//        write port, raddr/rdata read port. Array contents are never cleared.
module core_ibuf #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/core_msg_rx.sv
// Core-side task receiver: pulls scheduler words, decodes HDR/MASK/R0VEC/R0DATA/INSTR,
// loads r0 and the instruction buffer, then starts the program and waits for exec_done.
// Latency: one word per core_reading cycle, data one cycle behind the request; one idle
// cycle between frame sections. Backpressure: requests stop at once when stream_valid is
// low and never run past the current section's word count; in-flight words are kept.
// Ports: clk/reset (async active-low); stream_valid/mess_to_core/core_reading scheduler
// stream; core_ready status; r0_we/r0_data r0 load; prog_start/prog_len/fence_out/exec_done
// execution handshake; ibuf_raddr/ibuf_rdata core fetch port; ibuf_ovf sticky overflow.
// Build option CORE_MSG_RX_STATS_EN adds task_cnt/skip_cnt saturating task counters.
module core_msg_rx
    import core_msg_rx_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int CORE_NUM    = 16,
    parameter int BUS_TO_CORE = 16,
    parameter int R0_DEPTH    = 8,
    parameter int IBUF_DEPTH  = 1024,
    parameter int IBUF_AW     = $clog2(IBUF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stream_valid,
    input  logic [BUS_TO_CORE-1:0] mess_to_core,
    output logic                   core_reading,
    output logic                   core_ready,
    output logic                   r0_we,
    output logic [15:0]            r0_data,
    output logic                   prog_start,
    output logic [IBUF_AW:0]       prog_len,
    output logic [1:0]             fence_out,
    input  logic                   exec_done,
    input  logic [IBUF_AW-1:0]     ibuf_raddr,
    output logic [15:0]            ibuf_rdata,
`ifdef CORE_MSG_RX_STATS_EN
    output logic [15:0]            task_cnt,
    output logic [15:0]            skip_cnt,
`endif
    output logic                   ibuf_ovf
);

    localparam int CNT_W   = 16;
    localparam int SEL_BIT = CORE_ID % CORE_NUM;
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] R0_DEPTH_C   = CNT_W'(R0_DEPTH);
    localparam logic [CNT_W-1:0] IBUF_DEPTH_C = CNT_W'(IBUF_DEPTH);
    localparam logic [CNT_W-1:0] R0_SEL_IDX   = CNT_W'(CORE_ID % R0_DEPTH);

    rx_state_t        state, state_nxt;
    logic             rd_q;
    logic [CNT_W-1:0] req_cnt;      // requests issued in the current section
    logic [CNT_W-1:0] cap_cnt;      // words captured in the current section
    logic [CNT_W-1:0] state_len;
    logic [CNT_W-1:0] instr_total;
    logic [CNT_W-1:0] prog_len_nxt;
    logic [5:0]       if_num;
    logic             sel;
    logic             r0sel;
    logic [15:0]      word;
    logic             mask_bit;
    logic             cap_last;
    logic             exec_entry;
    logic             ibuf_we;

    assign word     = mess_to_core[15:0];
    assign mask_bit = mess_to_core[SEL_BIT];

    assign instr_total  = CNT_W'(if_num) * CNT_W'(FRAME_WORDS);
    assign prog_len_nxt = (instr_total > IBUF_DEPTH_C) ? IBUF_DEPTH_C : instr_total;

    always_comb begin
        state_len = '0;
        case (state)
            ST_HDR, ST_MASK, ST_R0VEC: state_len = ONE;
            ST_R0DATA:                 state_len = R0_DEPTH_C;
            ST_INSTR:                  state_len = instr_total;
            default:                   state_len = '0;
        endcase
    end

    // IDLE and EXEC have zero length, so this alone keeps them from reading.
    assign core_reading = stream_valid && (req_cnt < state_len);
    assign cap_last     = rd_q && (cap_cnt == state_len - ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (stream_valid) state_nxt = ST_HDR;
            ST_HDR:    if (rd_q) state_nxt = ST_MASK;
            ST_MASK:   if (rd_q) state_nxt = ST_R0VEC;
            ST_R0VEC:  if (rd_q) state_nxt = ST_R0DATA;
            ST_R0DATA: if (cap_last) state_nxt = (if_num == 6'd0) ? ST_HDR : ST_INSTR;
            ST_INSTR:  if (cap_last) state_nxt = sel ? ST_EXEC : ST_HDR;
            ST_EXEC:   if (exec_done) state_nxt = ST_HDR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign exec_entry = (state != ST_EXEC) && (state_nxt == ST_EXEC);
    assign ibuf_we    = (state == ST_INSTR) && rd_q && sel && (cap_cnt < IBUF_DEPTH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rd_q       <= 1'b0;
            req_cnt    <= '0;
            cap_cnt    <= '0;
            if_num     <= '0;
            sel        <= 1'b0;
            r0sel      <= 1'b0;
            fence_out  <= '0;
            r0_we      <= 1'b0;
            r0_data    <= '0;
            prog_start <= 1'b0;
            prog_len   <= '0;
            core_ready <= 1'b1;
            ibuf_ovf   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_q       <= core_reading;
            r0_we      <= 1'b0;
            prog_start <= 1'b0;

            if (state_nxt != state) begin
                req_cnt <= '0;
                cap_cnt <= '0;
            end else begin
                if (core_reading) req_cnt <= req_cnt + ONE;
                if (rd_q)         cap_cnt <= cap_cnt + ONE;
            end

            if (rd_q) begin
                case (state)
                    ST_HDR: begin
                        if_num    <= hdr_if_num(word);
                        fence_out <= hdr_fence(word);
                    end
                    ST_MASK: begin
                        sel <= mask_bit;
                        if (mask_bit) core_ready <= 1'b0;
                    end
                    ST_R0VEC: r0sel <= mask_bit;
                    ST_R0DATA: begin
                        if ((cap_cnt == R0_SEL_IDX) && sel && r0sel) begin
                            r0_we   <= 1'b1;
                            r0_data <= word;
                        end
                        // A selected task with no instructions never reaches EXEC,
                        // so the core is idle again once r0 is loaded.
                        if (cap_last && (if_num == 6'd0)) core_ready <= 1'b1;
                    end
                    ST_INSTR: begin
                        if (sel && (cap_cnt >= IBUF_DEPTH_C)) ibuf_ovf <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (exec_entry) begin
                prog_start <= 1'b1;
                prog_len   <= prog_len_nxt[IBUF_AW:0];
            end

            if ((state == ST_EXEC) && exec_done) core_ready <= 1'b1;
        end
    end

`ifdef CORE_MSG_RX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            task_cnt <= '0;
            skip_cnt <= '0;
        end else begin
            if (exec_entry && (task_cnt != 16'hFFFF)) task_cnt <= task_cnt + 16'd1;
            if ((state == ST_MASK) && rd_q && !mask_bit && (skip_cnt != 16'hFFFF))
                skip_cnt <= skip_cnt + 16'd1;
        end
    end
`endif

    core_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .AW    (IBUF_AW),
        .DW    (16)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .we    (ibuf_we),
        .waddr (cap_cnt[IBUF_AW-1:0]),
        .wdata (word),
        .raddr (ibuf_raddr),
        .rdata (ibuf_rdata)
    );

endmodule

// File: tb/tb_core_msg_rx.sv
module tb_core_msg_rx;

    localparam int CID = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stream_valid = 1'b0;
    logic [15:0] mess_to_core = 16'h0;
    logic        exec_done = 1'b0;
    logic [9:0]  ibuf_raddr = '0;
    logic [4:0]  ibuf_raddr_s = '0;

    logic        core_reading, core_ready, r0_we, prog_start, ibuf_ovf;
    logic [15:0] r0_data, ibuf_rdata;
    logic [10:0] prog_len;
    logic [1:0]  fence_out;

    logic        core_reading_s, core_ready_s, r0_we_s, prog_start_s, ibuf_ovf_s;
    logic [15:0] r0_data_s, ibuf_rdata_s;
    logic [5:0]  prog_len_s;
    logic [1:0]  fence_out_s;

    core_msg_rx #(.CORE_ID(CID)) dut (
        .clk(clk), .reset(reset), .stream_valid(stream_valid), .mess_to_core(mess_to_core),
        .core_reading(core_reading), .core_ready(core_ready), .r0_we(r0_we), .r0_data(r0_data),
        .prog_start(prog_start), .prog_len(prog_len), .fence_out(fence_out), .exec_done(exec_done),
        .ibuf_raddr(ibuf_raddr), .ibuf_rdata(ibuf_rdata), .ibuf_ovf(ibuf_ovf)
    );

    // Small-buffer instance fed the identical stream to exercise overflow
    core_msg_rx #(.CORE_ID(CID), .IBUF_DEPTH(32)) dut_s (
        .clk(clk), .reset(reset), .stream_valid(stream_valid), .mess_to_core(mess_to_core),
        .core_reading(core_reading_s), .core_ready(core_ready_s), .r0_we(r0_we_s), .r0_data(r0_data_s),
        .prog_start(prog_start_s), .prog_len(prog_len_s), .fence_out(fence_out_s), .exec_done(exec_done),
        .ibuf_raddr(ibuf_raddr_s), .ibuf_rdata(ibuf_rdata_s), .ibuf_ovf(ibuf_ovf_s)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scheduler model: a queue of pending words, one popped per read request
    logic [15:0] sq [$];
    bit          pending = 0;
    int          rd_cycles, r0_we_cnt, prog_start_cnt, stall_at, stall_len;
    logic [15:0] r0_seen;
    logic [10:0] plen_seen;
    logic [5:0]  plen_s_seen;
    bit          ready_low_seen;

    // Expected instruction buffer contents
    logic [15:0] exp_ibuf [1024];
    bit          known [1024];
    logic [15:0] exp_ibuf_s [32];
    bit          known_s [32];
    bit          ovf_s_exp = 0;

    task automatic cycle();
        @(negedge clk);
        if (pending) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL overread: read request with no word left (got 0 words, need >=1)");
                mess_to_core = 16'($urandom);
            end else begin
                mess_to_core = sq.pop_front();
            end
            pending = 0;
        end else begin
            mess_to_core = 16'($urandom);
        end
        if (stall_len > 0 && rd_cycles >= stall_at) begin
            stream_valid = 1'b0;
            stall_len--;
        end else begin
            stream_valid = (sq.size() > 0);
        end
        #1;
        if (core_reading) begin
            pending = 1;
            rd_cycles++;
        end
        if (r0_we) begin
            r0_we_cnt++;
            r0_seen = r0_data;
        end
        if (prog_start) begin
            prog_start_cnt++;
            plen_seen   = prog_len;
            plen_s_seen = prog_len_s;
        end
        if (!core_ready) ready_low_seen = 1;
    endtask

    task automatic read_ibuf(input int a, output logic [15:0] d, output logic [15:0] ds);
        ibuf_raddr   = a[9:0];
        ibuf_raddr_s = a[4:0];
        cycle();
        d  = ibuf_rdata;
        ds = ibuf_rdata_s;
    endtask

    task automatic run_task(input logic [15:0] hdr, input logic [15:0] mask, input logic [15:0] r0vec,
                            input bit det, input int stall_pos, input string name);
        logic [15:0] r0w [8];
        logic [15:0] ins [$];
        logic [15:0] d, ds;
        int n, nwords, limit, cyc, exp_len, exp_len_s, exp_r0_cnt;
        bit s, exec_exp;
        n          = int'(hdr[5:0]) * 16;
        s          = mask[CID];
        exec_exp   = s && (n > 0);
        nwords     = 11 + n;
        exp_r0_cnt = (s && r0vec[CID]) ? 1 : 0;
        exp_len    = (n > 1024) ? 1024 : n;
        exp_len_s  = (n > 32) ? 32 : n;
        sq.push_back(hdr);
        sq.push_back(mask);
        sq.push_back(r0vec);
        for (int i = 0; i < 8; i++) begin
            r0w[i] = det ? (16'hA000 + 16'(i)) : 16'($urandom);
            sq.push_back(r0w[i]);
        end
        for (int i = 0; i < n; i++) begin
            ins.push_back(det ? (16'hB000 + 16'(i)) : 16'($urandom));
            sq.push_back(ins[i]);
        end
        rd_cycles = 0; r0_we_cnt = 0; prog_start_cnt = 0; ready_low_seen = 0;
        stall_at  = stall_pos;
        stall_len = (stall_pos >= 0) ? 5 : 0;
        cyc = 0;
        limit = 2 * nwords + 60;
        while ((sq.size() > 0 || pending || (exec_exp && prog_start_cnt == 0)) && cyc < limit) begin
            cycle();
            cyc++;
        end
        repeat (3) cycle();

        checks++;
        if (cyc >= limit) begin
            errors++;
            $display("FAIL %s timeout: used %0d cycles, limit %0d", name, cyc, limit);
        end
        checks++;
        if (rd_cycles != nwords) begin
            errors++;
            $display("FAIL %s read_count got %0d exp %0d", name, rd_cycles, nwords);
        end
        checks++;
        if (r0_we_cnt != exp_r0_cnt) begin
            errors++;
            $display("FAIL %s r0_we_count got %0d exp %0d", name, r0_we_cnt, exp_r0_cnt);
        end
        if (exp_r0_cnt == 1) begin
            checks++;
            if (r0_seen !== r0w[CID % 8]) begin
                errors++;
                $display("FAIL %s r0_data got %h exp %h", name, r0_seen, r0w[CID % 8]);
            end
        end
        checks++;
        if (prog_start_cnt != (exec_exp ? 1 : 0)) begin
            errors++;
            $display("FAIL %s prog_start_count got %0d exp %0d", name, prog_start_cnt, exec_exp ? 1 : 0);
        end
        if (exec_exp) begin
            checks++;
            if (plen_seen !== 11'(exp_len) || plen_s_seen !== 6'(exp_len_s)) begin
                errors++;
                $display("FAIL %s prog_len got %0d/%0d exp %0d/%0d", name, plen_seen, plen_s_seen, exp_len, exp_len_s);
            end
        end
        checks++;
        if (fence_out !== hdr[7:6]) begin
            errors++;
            $display("FAIL %s fence_out got %0d exp %0d", name, fence_out, hdr[7:6]);
        end
        checks++;
        if (ready_low_seen != s) begin
            errors++;
            $display("FAIL %s core_ready_dropped got %0d exp %0d", name, ready_low_seen, s);
        end
        checks++;
        if (core_ready !== !exec_exp) begin
            errors++;
            $display("FAIL %s core_ready got %b exp %b", name, core_ready, !exec_exp);
        end

        if (s) begin
            for (int i = 0; i < n; i++) begin
                if (i < 1024) begin exp_ibuf[i] = ins[i]; known[i] = 1; end
                if (i < 32) begin exp_ibuf_s[i] = ins[i]; known_s[i] = 1; end
            end
            if (n > 32) ovf_s_exp = 1;
        end
        checks++;
        if (ibuf_ovf !== 1'b0 || ibuf_ovf_s !== ovf_s_exp) begin
            errors++;
            $display("FAIL %s ibuf_ovf got %b/%b exp 0/%b", name, ibuf_ovf, ibuf_ovf_s, ovf_s_exp);
        end

        for (int a = 0; a < 48; a++) begin
            read_ibuf(a, d, ds);
            if (known[a]) begin
                checks++;
                if (d !== exp_ibuf[a]) begin
                    errors++;
                    $display("FAIL %s ibuf[%0d] got %h exp %h", name, a, d, exp_ibuf[a]);
                end
            end
            if (a < 32 && known_s[a]) begin
                checks++;
                if (ds !== exp_ibuf_s[a]) begin
                    errors++;
                    $display("FAIL %s ibuf_small[%0d] got %h exp %h", name, a, ds, exp_ibuf_s[a]);
                end
            end
        end

        if (exec_exp) begin
            exec_done = 1'b1;
            cycle();
            exec_done = 1'b0;
            checks++;
            if (core_ready !== 1'b1 || core_ready_s !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_after_done got %b/%b exp 1/1", name, core_ready, core_ready_s);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (core_ready !== 1'b1 || core_reading !== 1'b0 || r0_we !== 1'b0 || prog_start !== 1'b0 ||
            prog_len !== 11'd0 || fence_out !== 2'd0 || ibuf_ovf !== 1'b0 || r0_data !== 16'h0 ||
            ibuf_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got ready=%b rd=%b we=%b ps=%b len=%0d fence=%0d ovf=%b r0=%h rdata=%h exp ready=1 others 0",
                     core_ready, core_reading, r0_we, prog_start, prog_len, fence_out, ibuf_ovf, r0_data, ibuf_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_selected();
        run_task(16'h0002, 16'h0008, 16'h0008, 1, -1, "selected");
    endtask

    task automatic test_unselected();
        exec_done = 1'b1;   // ignored outside EXEC
        run_task(16'h0002, 16'h0004, 16'h0008, 1, -1, "unselected");
        exec_done = 1'b0;
        run_task(16'h0041, 16'h0008, 16'h0000, 0, -1, "after_unselected");
    endtask

    task automatic test_ifnum_zero();
        run_task(16'h00C0, 16'h0008, 16'h0008, 0, -1, "ifnum_zero");
    endtask

    task automatic test_stall();
        run_task(16'h0082, 16'hFFFF, 16'h0008, 0, 25, "stall_instr");
        run_task(16'h0001, 16'h0008, 16'h0008, 0, 6, "stall_r0");
    endtask

    task automatic test_ovf();
        run_task(16'h0003, 16'h0008, 16'h0000, 0, -1, "ovf");
    endtask

    task automatic test_reset_mid();
        int cyc;
        for (int i = 0; i < 3; i++) sq.push_back(16'h0008);
        sq[0] = 16'h0002;
        for (int i = 0; i < 40; i++) sq.push_back(16'($urandom));
        rd_cycles = 0;
        cyc = 0;
        while (rd_cycles < 7 && cyc < 100) begin
            cycle();
            cyc++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (core_ready !== 1'b1 || core_reading !== 1'b0 || r0_we !== 1'b0 || ibuf_ovf_s !== 1'b0 ||
            fence_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid got ready=%b rd=%b we=%b ovf_s=%b fence=%0d exp 1 0 0 0 0",
                     core_ready, core_reading, r0_we, ibuf_ovf_s, fence_out);
        end
        sq.delete();
        pending   = 0;
        ovf_s_exp = 0;
        repeat (2) cycle();
        reset = 1'b1;
        run_task(16'h0042, 16'h0008, 16'h0008, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] hdr, mask, r0vec;
        int n;
        for (int k = 0; k < 10; k++) begin
            hdr   = {8'($urandom), 2'($urandom), 6'($urandom_range(0, 3))};
            mask  = 16'($urandom);
            mask[CID] = ($urandom_range(0, 1) == 1);
            r0vec = 16'($urandom);
            n = int'(hdr[5:0]) * 16;
            run_task(hdr, mask, r0vec, 0,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 + n)) : -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_selected();
        test_unselected();
        test_ifnum_zero();
        test_stall();
        test_ovf();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
